// File: rtl/systolic_array_nxn_if.sv
// Operand/result handshake bundle for the NxN systolic multiplier.
// master = feeder/sink side, slave = the array.
interface systolic_array_nxn_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 3,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
);
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic [N*DATA_WIDTH-1:0]    a_col;
  logic [N*DATA_WIDTH-1:0]    b_row;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready;
  logic [N*N*ACC_WIDTH-1:0]   c_flat;

  modport master (
    output start, in_valid, a_col, b_row, out_ready,
    input  in_ready, busy, out_valid, c_flat
  );

  modport slave (
    input  start, in_valid, a_col, b_row, out_ready,
    output in_ready, busy, out_valid, c_flat
  );
endinterface

// File: rtl/systolic_array_nxn.sv
// Output-stationary NxN systolic multiplier C = A*B with internal input skew,
// start/busy/done control and a held, handshaked result.
module systolic_array_nxn #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 3,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
  input logic                 clk,
  input logic                 rst,
  systolic_array_nxn_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned EXT_W  = ACC_WIDTH - PROD_W;
  localparam int unsigned CNT_W  = $clog2(2 * N);
  localparam bit          IS_SGN = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, busy_q, out_valid_q;
  logic [N*N*ACC_WIDTH-1:0] c_flat_q;
  logic [N*N*ACC_WIDTH-1:0] acc_flat;
  logic                     fire, clear, run, capture;

  logic [DATA_WIDTH-1:0]    a_lane [N];
  logic [DATA_WIDTH-1:0]    b_lane [N];
  logic [DATA_WIDTH-1:0]    a_pass [N][N-1];
  logic [DATA_WIDTH-1:0]    b_pass [N-1][N];

  assign fire  = in_ready_q && bus.in_valid;
  assign clear = !rst || (state_q == IDLE && bus.start);
  assign run   = (state_q == LOAD) || (state_q == DRAIN);

  // Next-state: counter holds beat index in LOAD, remaining drain cycles in DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (fire) begin
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(2 * N - 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      c_flat_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == LOAD);
      busy_q      <= (state_d == LOAD) || (state_d == DRAIN);
      out_valid_q <= (state_d == DONE);
      if (capture) c_flat_q <= acc_flat;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c_flat    = c_flat_q;

  // Input skew: lane i sits behind i+1 registers; idle LOAD/DRAIN cycles inject zeros
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_WIDTH-1:0] a_sr [0:gi];
    logic [DATA_WIDTH-1:0] b_sr [0:gi];

    always_ff @(posedge clk) begin
      if (clear) begin
        for (int k = 0; k <= gi; k++) begin
          a_sr[k] <= '0;
          b_sr[k] <= '0;
        end
      end else if (run) begin
        a_sr[0] <= fire ? bus.a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_sr[0] <= fire ? bus.b_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= gi; k++) begin
          a_sr[k] <= a_sr[k-1];
          b_sr[k] <= b_sr[k-1];
        end
      end
    end

    assign a_lane[gi] = a_sr[gi];
    assign b_lane[gi] = b_sr[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [DATA_WIDTH-1:0] a_in, b_in;
      logic [PROD_W-1:0]     prod;
      logic [ACC_WIDTH-1:0]  prod_ext;
      logic [ACC_WIDTH-1:0]  acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_lane[gi];
      end else begin : g_a_int
        assign a_in = a_pass[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in = b_lane[gj];
      end else begin : g_b_int
        assign b_in = b_pass[gi-1][gj];
      end

      // Low 2W bits of the extended-operand product equal the true signed/unsigned product
      assign prod = {{DATA_WIDTH{IS_SGN && a_in[DATA_WIDTH-1]}}, a_in}
                  * {{DATA_WIDTH{IS_SGN && b_in[DATA_WIDTH-1]}}, b_in};
      assign prod_ext = {{EXT_W{IS_SGN && prod[PROD_W-1]}}, prod};

      always_ff @(posedge clk) begin
        if (clear) begin
          acc_q <= '0;
        end else if (run) begin
          acc_q <= acc_q + prod_ext;
        end
      end

      assign acc_flat[(gi*N+gj)*ACC_WIDTH +: ACC_WIDTH] = acc_q;

      if (gj < N - 1) begin : g_a_fwd
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk) begin
          if (clear) a_q <= '0;
          else if (run) a_q <= a_in;
        end
        assign a_pass[gi][gj] = a_q;
      end

      if (gi < N - 1) begin : g_b_fwd
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk) begin
          if (clear) b_q <= '0;
          else if (run) b_q <= b_in;
        end
        assign b_pass[gi][gj] = b_q;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Bench for systolic_array_nxn: unsigned N=3 and signed N=4 instances checked
// against a matrix-product reference model and the cycle-level timing rules.
module tb_systolic_array_nxn;

  localparam int unsigned DW   = 8;
  localparam int unsigned N0   = 3;
  localparam int unsigned ACC0 = 2 * DW + $clog2(N0);
  localparam int unsigned N1   = 4;
  localparam int unsigned ACC1 = 2 * DW + $clog2(N1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_array_nxn_if #(.DATA_WIDTH(DW), .N(N0), .ACC_WIDTH(ACC0)) bus0 ();
  systolic_array_nxn_if #(.DATA_WIDTH(DW), .N(N1), .ACC_WIDTH(ACC1)) bus1 ();

  systolic_array_nxn #(.DATA_WIDTH(DW), .N(N0), .SIGNED(0), .ACC_WIDTH(ACC0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  systolic_array_nxn #(.DATA_WIDTH(DW), .N(N1), .SIGNED(1), .ACC_WIDTH(ACC1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int a0[N0][N0];
  int b0[N0][N0];
  int gap0[N0];
  logic [N0*N0*ACC0-1:0] exp0;

  int a1[N1][N1];
  int b1[N1][N1];
  logic [N1*N1*ACC1-1:0] exp1;

  int basic_c[N0*N0] = '{98, 106, 90, 124, 124, 108, 105, 111, 83};

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Reference: plain matrix product, truncated to the accumulator width
  task automatic model0();
    for (int i = 0; i < N0; i++)
      for (int j = 0; j < N0; j++) begin
        longint s = 0;
        for (int k = 0; k < N0; k++) s += longint'(a0[i][k]) * longint'(b0[k][j]);
        exp0[(i*N0+j)*ACC0 +: ACC0] = ACC0'(s);
      end
  endtask

  function automatic longint sval(input int v);
    return (v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  task automatic model1();
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N1; j++) begin
        longint s = 0;
        for (int k = 0; k < N1; k++) s += sval(a1[i][k]) * sval(b1[k][j]);
        exp1[(i*N1+j)*ACC1 +: ACC1] = ACC1'(s);
      end
  endtask

  task automatic rand0();
    for (int i = 0; i < N0; i++)
      for (int j = 0; j < N0; j++) begin
        a0[i][j] = int'($urandom_range(0, 255));
        b0[i][j] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic set_basic();
    int av[N0][N0] = '{'{7, 4, 7}, '{5, 6, 9}, '{1, 9, 5}};
    int bv[N0][N0] = '{'{2, 5, 3}, '{7, 9, 5}, '{8, 5, 7}};
    a0 = av;
    b0 = bv;
    for (int e = 0; e < N0 * N0; e++) exp0[e*ACC0 +: ACC0] = ACC0'(basic_c[e]);
  endtask

  // Present beat k (or random garbage on a bubble) to the N=3 instance
  task automatic beat0(input int k, input bit v);
    bus0.in_valid = v;
    for (int i = 0; i < N0; i++) begin
      bus0.a_col[i*DW +: DW] = v ? DW'(a0[i][k]) : DW'($urandom);
      bus0.b_row[i*DW +: DW] = v ? DW'(b0[k][i]) : DW'($urandom);
    end
  endtask

  task automatic beat1(input int k);
    bus1.in_valid = 1'b1;
    for (int i = 0; i < N1; i++) begin
      bus1.a_col[i*DW +: DW] = DW'(a1[i][k]);
      bus1.b_row[i*DW +: DW] = DW'(b1[k][i]);
    end
  endtask

  task automatic run0(input string tag, input bit pre_ready, input bit poke_start, input int hold);
    int s;
    int total = 0;
    for (int k = 0; k < N0; k++) total += gap0[k];
    bus0.out_ready = pre_ready;
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    s = cyc;
    chk({tag, " in_ready@S+1"}, 512'(bus0.in_ready), 512'(1));
    chk({tag, " busy@S+1"}, 512'(bus0.busy), 512'(1));
    for (int k = 0; k < N0; k++) begin
      for (int g = 0; g < gap0[k]; g++) begin
        beat0(k, 1'b0);
        tick();
      end
      beat0(k, 1'b1);
      tick();
    end
    bus0.in_valid = 1'b0;
    chk({tag, " in_ready after last beat"}, 512'(bus0.in_ready), 512'(0));
    chk({tag, " busy in drain"}, 512'(bus0.busy), 512'(1));
    if (poke_start) begin
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
    end
    while (!bus0.out_valid && (cyc - s) < 200) tick();
    chk({tag, " out_valid latency"}, 512'(cyc - s), 512'(3 * N0 + total));
    chk({tag, " busy at done"}, 512'(bus0.busy), 512'(0));
    chk({tag, " c_flat"}, 512'(bus0.c_flat), 512'(exp0));
    if (pre_ready) begin
      tick();
      chk({tag, " one-cycle hold"}, 512'(bus0.out_valid), 512'(0));
    end else begin
      for (int h = 0; h < hold; h++) begin
        bus0.start = (h == 2);
        tick();
        chk({tag, " held valid"}, 512'({bus0.out_valid, bus0.busy}), 512'(2'b10));
        chk({tag, " held c_flat"}, 512'(bus0.c_flat), 512'(exp0));
      end
      bus0.out_ready = 1'b1;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      chk({tag, " released"}, 512'({bus0.out_valid, bus0.busy}), 512'(2'b00));
    end
    bus0.out_ready = 1'b0;
    tick();
    chk({tag, " idle"}, 512'({bus0.out_valid, bus0.busy, bus0.in_ready}), 512'(3'b000));
    chk({tag, " c_flat kept in idle"}, 512'(bus0.c_flat), 512'(exp0));
  endtask

  task automatic run1(input string tag);
    int s;
    bus1.out_ready = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    s = cyc;
    for (int k = 0; k < N1; k++) begin
      beat1(k);
      tick();
    end
    bus1.in_valid = 1'b0;
    while (!bus1.out_valid && (cyc - s) < 200) tick();
    chk({tag, " out_valid latency"}, 512'(cyc - s), 512'(3 * N1));
    chk({tag, " c_flat"}, 512'(bus1.c_flat), 512'(exp1));
    tick();
    chk({tag, " one-cycle hold"}, 512'(bus1.out_valid), 512'(0));
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus0.start = 1'b0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus0.a_col = '0;   bus0.b_row = '0;
    bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a_col = '0;   bus1.b_row = '0;
    for (int k = 0; k < N0; k++) gap0[k] = 0;
    repeat (3) tick();
    chk("reset ctl0", 512'({bus0.in_ready, bus0.busy, bus0.out_valid}), 512'(3'b000));
    chk("reset c0", 512'(bus0.c_flat), 512'(0));
    chk("reset ctl1", 512'({bus1.in_ready, bus1.busy, bus1.out_valid}), 512'(3'b000));
    chk("reset c1", 512'(bus1.c_flat), 512'(0));
    rst = 1'b1;
    tick();

    set_basic();
    run0("basic", 1'b0, 1'b0, 1);

    gap0[1] = 2;
    gap0[2] = 1;
    run0("bubbles", 1'b0, 1'b0, 1);
    gap0[1] = 0;
    gap0[2] = 0;

    for (int i = 0; i < N0; i++)
      for (int j = 0; j < N0; j++) begin
        a0[i][j] = 255;
        b0[i][j] = 255;
      end
    for (int e = 0; e < N0 * N0; e++) exp0[e*ACC0 +: ACC0] = ACC0'(195075);
    run0("max", 1'b1, 1'b0, 0);

    rand0();
    model0();
    run0("handshake", 1'b0, 1'b1, 5);

    // Abort in DRAIN, then rerun the basic product
    set_basic();
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int k = 0; k < N0; k++) begin
      beat0(k, 1'b1);
      tick();
    end
    bus0.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort ctl", 512'({bus0.in_ready, bus0.busy, bus0.out_valid}), 512'(3'b000));
    chk("abort c_flat", 512'(bus0.c_flat), 512'(0));
    tick();
    run0("after abort", 1'b0, 1'b0, 1);

    for (int r = 0; r < 6; r++) begin
      rand0();
      model0();
      for (int k = 0; k < N0; k++) gap0[k] = int'($urandom_range(0, 2));
      run0($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'b0, 2);
    end

    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N1; j++) begin
        a1[i][j] = (i == j) ? 255 : 0;
        b1[i][j] = 2;
      end
    for (int e = 0; e < N1 * N1; e++) exp1[e*ACC1 +: ACC1] = ACC1'(18'h3FFFE);
    run1("signed neg identity");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N1; i++)
        for (int j = 0; j < N1; j++) begin
          a1[i][j] = int'($urandom_range(0, 255));
          b1[i][j] = int'($urandom_range(0, 255));
        end
      model1();
      run1($sformatf("signed rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
